// File: rtl/diff_drive_pwm.sv
// ---------------------------------------------------------------------------
// diff_drive_pwm
//
// Proportional differential-drive motor controller. Signed steering samples
// arrive over a valid/ready handshake and are turned into a left/right duty
// split around BASE_DUTY (deadband, right-shift gain, clamp to the PWM range).
// A watchdog drops to FAULT when samples stop arriving. Applied duties change
// only at PWM period boundaries, except that leaving RUN zeroes them at once.
//
// Optional feature macro: MOTOR_RAMP_EN
//   defined   : at each period boundary an applied duty moves toward its
//               target by at most RAMP_STEP
//   undefined : an applied duty jumps straight to its target at the boundary
//
// Ports:
//   clk               system clock
//   reset             asynchronous, active-high reset
//   i_enable          run request; low forces IDLE
//   i_steering        signed steering sample, positive = turn right
//   i_valid           steering sample valid
//   o_ready           block can accept a sample (registered)
//   o_left_motor_pwm  left motor PWM (registered)
//   o_right_motor_pwm right motor PWM (registered)
//   o_left_duty       currently applied left duty
//   o_right_duty      currently applied right duty
//   o_fault           watchdog fault flag
//
// Handshake: a sample is taken on a clock edge where i_valid and o_ready are
// both high; o_ready then drops for exactly the following cycle, so the peak
// rate is one sample every two cycles. i_valid may be held high.
// ---------------------------------------------------------------------------
module diff_drive_pwm #(
    parameter int STEERING_WIDTH = 10,
    parameter int PWM_RESOLUTION = 8,
    parameter int PRESCALE_WIDTH = 12,
    parameter int BASE_DUTY      = 77,
    parameter int DEADBAND       = 16,
    parameter int GAIN_SHIFT     = 2,
    parameter int WDT_WIDTH      = 24,
    parameter int WDT_LIMIT      = 5000000,
    parameter int RAMP_STEP      = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_enable,
    input  logic signed [STEERING_WIDTH-1:0] i_steering,
    input  logic                             i_valid,
    output logic                             o_ready,
    output logic                             o_left_motor_pwm,
    output logic                             o_right_motor_pwm,
    output logic [PWM_RESOLUTION-1:0]        o_left_duty,
    output logic [PWM_RESOLUTION-1:0]        o_right_duty,
    output logic                             o_fault
);

    localparam int SW = STEERING_WIDTH;
    localparam int N  = PWM_RESOLUTION;
    // Two guard bits over the wider of steering/duty: |min steering| and
    // BASE_DUTY +/- d both fit without overflow.
    localparam int AW = ((SW > N) ? SW : N) + 2;

    localparam logic signed [AW-1:0] DB_S   = AW'(DEADBAND);
    localparam logic signed [AW-1:0] BASE_S = AW'(BASE_DUTY);
    localparam logic signed [AW-1:0] MAX_S  = AW'((1 << N) - 1);
    localparam logic [WDT_WIDTH-1:0] WDT_LAST = WDT_WIDTH'(WDT_LIMIT - 1);

`ifdef MOTOR_RAMP_EN
    localparam bit RAMP_ON = 1'b1;
`else
    localparam bit RAMP_ON = 1'b0;
`endif
    // Without the ramp the step exceeds any possible gap, so the duty lands
    // on the target in one boundary.
    localparam int         STEP   = RAMP_ON ? RAMP_STEP : (1 << N);
    localparam logic [N:0] STEP_W = (N+1)'(STEP);
    localparam logic [N-1:0] STEP_N = N'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    ready_q;
    logic                    fault_q;
    logic [WDT_WIDTH-1:0]    wdt_q;
    logic signed [SW-1:0]    sample_q;
    logic                    s1_valid_q;
    logic [N-1:0]            tgt_l_q, tgt_r_q;
    logic [N-1:0]            tgt_l_d, tgt_r_d;
    logic [PRESCALE_WIDTH-1:0] presc_q;
    logic [N-1:0]            cnt_q, cnt_d;
    logic [N-1:0]            duty_l_q, duty_r_q, duty_l_d, duty_r_d;
    logic                    pwm_l_q, pwm_r_q;
    logic                    accept;
    logic                    tick;
    logic                    wrap;

    assign accept = i_valid && ready_q;
    assign tick   = &presc_q;
    assign wrap   = tick && (&cnt_q);

    function automatic logic [N-1:0] clamp_duty(input logic signed [AW-1:0] v);
        if (v[AW-1])
            return '0;
        else if (v > MAX_S)
            return '1;
        else
            return v[N-1:0];
    endfunction

    function automatic logic [N-1:0] approach(input logic [N-1:0] cur,
                                              input logic [N-1:0] tgt);
        logic [N:0] gap;
        if (tgt > cur) begin
            gap = {1'b0, tgt} - {1'b0, cur};
            return (gap > STEP_W) ? (cur + STEP_N) : tgt;
        end else begin
            gap = {1'b0, cur} - {1'b0, tgt};
            return (gap > STEP_W) ? (cur - STEP_N) : tgt;
        end
    endfunction

    // Stage 2 arithmetic on the registered sample.
    always_comb begin
        logic signed [AW-1:0] s_ext, mag, diff;
        s_ext = {{(AW-SW){sample_q[SW-1]}}, sample_q};
        mag   = s_ext[AW-1] ? -s_ext : s_ext;
        diff  = (mag > DB_S) ? ((mag - DB_S) >>> GAIN_SHIFT) : '0;
        if (!s_ext[AW-1]) begin
            tgt_l_d = clamp_duty(BASE_S + diff);
            tgt_r_d = clamp_duty(BASE_S - diff);
        end else begin
            tgt_l_d = clamp_duty(BASE_S - diff);
            tgt_r_d = clamp_duty(BASE_S + diff);
        end
    end

    // Control FSM next state; an accept beats a same-cycle watchdog expiry.
    always_comb begin
        state_d = state_q;
        if (!i_enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_FAULT: if (accept) state_d = ST_RUN;
                ST_RUN:            if (!accept && (wdt_q >= WDT_LAST)) state_d = ST_FAULT;
                default:           state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            fault_q <= 1'b0;
            wdt_q   <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= (state_d == ST_FAULT);
            if ((state_d != ST_RUN) || accept)
                wdt_q <= '0;
            else if (wdt_q < WDT_LAST)
                wdt_q <= wdt_q + 1'b1;
        end
    end

    // Handshake and the two-stage sample pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q    <= 1'b1;
            sample_q   <= '0;
            s1_valid_q <= 1'b0;
            tgt_l_q    <= '0;
            tgt_r_q    <= '0;
        end else begin
            ready_q    <= !accept;
            s1_valid_q <= accept;
            if (accept)
                sample_q <= i_steering;
            if (state_q != ST_RUN) begin
                tgt_l_q <= '0;
                tgt_r_q <= '0;
            end else if (s1_valid_q) begin
                tgt_l_q <= tgt_l_d;
                tgt_r_q <= tgt_r_d;
            end
        end
    end

    // PWM counter and applied duties. The PWM flops compare the next counter
    // against the next duty so they line up with the counter register.
    always_comb begin
        cnt_d    = tick ? (cnt_q + 1'b1) : cnt_q;
        duty_l_d = duty_l_q;
        duty_r_d = duty_r_q;
        if (state_d != ST_RUN) begin
            duty_l_d = '0;
            duty_r_d = '0;
        end else if (wrap) begin
            duty_l_d = approach(duty_l_q, tgt_l_q);
            duty_r_d = approach(duty_r_q, tgt_r_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q  <= '0;
            cnt_q    <= '0;
            duty_l_q <= '0;
            duty_r_q <= '0;
            pwm_l_q  <= 1'b0;
            pwm_r_q  <= 1'b0;
        end else begin
            presc_q  <= presc_q + 1'b1;
            cnt_q    <= cnt_d;
            duty_l_q <= duty_l_d;
            duty_r_q <= duty_r_d;
            pwm_l_q  <= (cnt_d < duty_l_d);
            pwm_r_q  <= (cnt_d < duty_r_d);
        end
    end

    assign o_ready           = ready_q;
    assign o_fault           = fault_q;
    assign o_left_duty       = duty_l_q;
    assign o_right_duty      = duty_r_q;
    assign o_left_motor_pwm  = pwm_l_q;
    assign o_right_motor_pwm = pwm_r_q;

endmodule

// File: tb/tb_diff_drive_pwm.sv
// ---------------------------------------------------------------------------
// tb_diff_drive_pwm
//
// Directed bench for diff_drive_pwm with a 4-clock prescaler (1024-clock PWM
// period) and a 100-clock watchdog. Expected duties are hand-computed from
// the steering arithmetic. A free-running edge counter mirrors the period so
// boundaries are located without reading the design.
// ---------------------------------------------------------------------------
module tb_diff_drive_pwm;

    localparam int SW     = 10;
    localparam int N      = 8;
    localparam int PERIOD = 1024;

    logic                 clk;
    logic                 reset;
    logic                 i_enable;
    logic signed [SW-1:0] i_steering;
    logic                 i_valid;
    logic                 o_ready;
    logic                 o_left_motor_pwm;
    logic                 o_right_motor_pwm;
    logic [N-1:0]         o_left_duty;
    logic [N-1:0]         o_right_duty;
    logic                 o_fault;

    logic signed [SW-1:0] cur_s;
    int                   total;
    int                   bad;
    int                   edge_cnt;

    diff_drive_pwm #(
        .STEERING_WIDTH(SW),
        .PWM_RESOLUTION(N),
        .PRESCALE_WIDTH(2),
        .BASE_DUTY(77),
        .DEADBAND(16),
        .GAIN_SHIFT(2),
        .WDT_WIDTH(24),
        .WDT_LIMIT(100),
        .RAMP_STEP(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_enable(i_enable),
        .i_steering(i_steering),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_left_motor_pwm(o_left_motor_pwm),
        .o_right_motor_pwm(o_right_motor_pwm),
        .o_left_duty(o_left_duty),
        .o_right_duty(o_right_duty),
        .o_fault(o_fault)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // driver tasks
    task automatic send_sample(input logic signed [SW-1:0] s);
        int tries;
        tries = 0;
        @(negedge clk);
        cur_s      = s;
        i_steering = s;
        i_valid    = 1'b1;
        while (!o_ready && tries < 8) begin
            @(negedge clk);
            tries++;
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        total++;
        if (tries >= 8) begin
            bad++;
            $display("FAIL send_timeout: waited %0d cycles, required < 8", tries);
        end
        total++;
        if (o_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_drop: o_ready=%0b required 0", o_ready);
        end
    endtask

    // Advance to just after the next period boundary, optionally re-sending
    // the current sample every 32 cycles to keep the watchdog fed.
    task automatic run_to_wrap(input bit keep);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            i_steering = cur_s;
            i_valid    = keep && ((n % 32) == 0);
            n++;
            @(posedge clk);
            #1;
        end while (((edge_cnt % PERIOD) != 0) && (n < 3000));
        i_valid = 1'b0;
    endtask

    task automatic count_period(input bit keep, output int hl, output int hr);
        hl = 0;
        hr = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (o_left_motor_pwm)  hl++;
            if (o_right_motor_pwm) hr++;
            @(negedge clk);
            i_valid = keep && ((i % 32) == 31);
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
    endtask

    // scenarios
    task automatic test_reset;
        reset      = 1'b1;
        i_enable   = 1'b0;
        i_valid    = 1'b0;
        i_steering = '0;
        cur_s      = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({o_ready, o_fault, o_left_motor_pwm, o_right_motor_pwm} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_flags: {ready,fault,pwm_l,pwm_r}=%b required 1000",
                     {o_ready, o_fault, o_left_motor_pwm, o_right_motor_pwm});
        end
        total++;
        if ({o_left_duty, o_right_duty} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_duty: l=%0d r=%0d required 0/0", o_left_duty, o_right_duty);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({o_ready, o_fault, o_left_duty, o_right_duty} !== {2'b10, 16'h0000}) begin
            bad++;
            $display("FAIL idle_after_reset: ready=%0b fault=%0b l=%0d r=%0d required 1/0/0/0",
                     o_ready, o_fault, o_left_duty, o_right_duty);
        end
    endtask

    task automatic test_zero_steer;
        int hl, hr;
        @(negedge clk);
        i_enable = 1'b1;
        send_sample(10'sd0);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (o_left_duty !== 8'd0 || o_right_duty !== 8'd0) begin
            bad++;
            $display("FAIL zero_before_wrap: l=%0d r=%0d required 0/0", o_left_duty, o_right_duty);
        end
        run_to_wrap(1'b1);
        total++;
        if (o_left_duty !== 8'd77 || o_right_duty !== 8'd77) begin
            bad++;
            $display("FAIL zero_duty: l=%0d r=%0d required 77/77", o_left_duty, o_right_duty);
        end
        count_period(1'b1, hl, hr);
        total++;
        if (hl != 308 || hr != 308) begin
            bad++;
            $display("FAIL zero_pwm_high: l=%0d r=%0d clocks required 308/308", hl, hr);
        end
    endtask

    task automatic test_steering;
        int sv [7] = '{200, -200, 10, 16, 20, -512, 511};
        int el [7] = '{123, 31, 77, 77, 78, 0, 200};
        int er [7] = '{31, 123, 77, 77, 76, 201, 0};
        int pl, pr, hl, hr;
        pl = 77;
        pr = 77;
        for (int i = 0; i < 7; i++) begin
            send_sample(10'(sv[i]));
            repeat (4) @(posedge clk);
            #1;
            total++;
            if (int'(o_left_duty) != pl || int'(o_right_duty) != pr) begin
                bad++;
                $display("FAIL steer_mid_period s=%0d: l=%0d r=%0d required %0d/%0d",
                         sv[i], o_left_duty, o_right_duty, pl, pr);
            end
            run_to_wrap(1'b1);
            total++;
            if (int'(o_left_duty) != el[i] || int'(o_right_duty) != er[i]) begin
                bad++;
                $display("FAIL steer_duty s=%0d: l=%0d r=%0d required %0d/%0d",
                         sv[i], o_left_duty, o_right_duty, el[i], er[i]);
            end
            if (i == 0) begin
                count_period(1'b1, hl, hr);
                total++;
                if (hl != 492 || hr != 124) begin
                    bad++;
                    $display("FAIL steer_pwm_high: l=%0d r=%0d clocks required 492/124", hl, hr);
                end
            end
            pl = el[i];
            pr = er[i];
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_rdy;
        int acc;
        exp_rdy = 4'b1010;
        acc     = 0;
        repeat (3) @(negedge clk);
        cur_s      = 10'sd200;
        i_steering = 10'sd200;
        i_valid    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (o_ready) acc++;
            @(posedge clk);
            #1;
            total++;
            if (o_ready !== exp_rdy[i]) begin
                bad++;
                $display("FAIL b2b_ready[%0d]: o_ready=%0b required %0b", i, o_ready, exp_rdy[i]);
            end
            if (i < 3) @(negedge clk);
        end
        @(negedge clk);
        i_valid = 1'b0;
        total++;
        if (acc != 2) begin
            bad++;
            $display("FAIL b2b_accepts: %0d accepts required 2", acc);
        end
        total++;
        if (o_left_duty !== 8'd200 || o_right_duty !== 8'd0) begin
            bad++;
            $display("FAIL b2b_mid_period: l=%0d r=%0d required 200/0", o_left_duty, o_right_duty);
        end
        run_to_wrap(1'b1);
        total++;
        if (o_left_duty !== 8'd123 || o_right_duty !== 8'd31) begin
            bad++;
            $display("FAIL b2b_duty: l=%0d r=%0d required 123/31", o_left_duty, o_right_duty);
        end
    endtask

    task automatic test_watchdog;
        int n;
        send_sample(10'sd200);
        n = 0;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (o_fault) break;
        end
        total++;
        if (n != 100) begin
            bad++;
            $display("FAIL wdt_latency: fault after %0d cycles required 100", n);
        end
        total++;
        if (o_fault !== 1'b1 || o_left_duty !== 8'd0 || o_right_duty !== 8'd0) begin
            bad++;
            $display("FAIL wdt_fault_state: fault=%0b l=%0d r=%0d required 1/0/0",
                     o_fault, o_left_duty, o_right_duty);
        end
        @(posedge clk);
        #1;
        total++;
        if (o_left_motor_pwm !== 1'b0 || o_right_motor_pwm !== 1'b0 || o_fault !== 1'b1) begin
            bad++;
            $display("FAIL wdt_pwm_low: pwm_l=%0b pwm_r=%0b fault=%0b required 0/0/1",
                     o_left_motor_pwm, o_right_motor_pwm, o_fault);
        end
        send_sample(10'sd0);
        total++;
        if (o_fault !== 1'b0) begin
            bad++;
            $display("FAIL wdt_recover: o_fault=%0b required 0", o_fault);
        end
        run_to_wrap(1'b1);
        total++;
        if (o_left_duty !== 8'd77 || o_right_duty !== 8'd77) begin
            bad++;
            $display("FAIL wdt_recover_duty: l=%0d r=%0d required 77/77", o_left_duty, o_right_duty);
        end
        @(negedge clk);
        i_enable = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (o_left_duty !== 8'd0 || o_right_duty !== 8'd0 || o_fault !== 1'b0) begin
            bad++;
            $display("FAIL disable_idle: l=%0d r=%0d fault=%0b required 0/0/0",
                     o_left_duty, o_right_duty, o_fault);
        end
        run_to_wrap(1'b1);
        total++;
        if (o_left_duty !== 8'd0 || o_right_duty !== 8'd0) begin
            bad++;
            $display("FAIL disabled_samples: l=%0d r=%0d required 0/0", o_left_duty, o_right_duty);
        end
        @(negedge clk);
        i_enable = 1'b1;
    endtask

    task automatic test_async_reset;
        send_sample(10'sd0);
        run_to_wrap(1'b1);
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (o_left_motor_pwm !== 1'b1 || o_right_motor_pwm !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_pwm: pwm_l=%0b pwm_r=%0b required 1/1",
                     o_left_motor_pwm, o_right_motor_pwm);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({o_left_motor_pwm, o_right_motor_pwm, o_ready} !== 3'b001 ||
            o_left_duty !== 8'd0 || o_right_duty !== 8'd0) begin
            bad++;
            $display("FAIL async_reset: pwm_l=%0b pwm_r=%0b ready=%0b l=%0d r=%0d required 0/0/1/0/0",
                     o_left_motor_pwm, o_right_motor_pwm, o_ready, o_left_duty, o_right_duty);
        end
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        i_enable = 1'b0;
    endtask

    task automatic test_ramp;
        int exp_d, n;
        @(negedge clk);
        i_enable = 1'b1;
        send_sample(10'sd0);
        for (int k = 1; k <= 20; k++) begin
            run_to_wrap(1'b1);
            exp_d = (4 * k < 77) ? 4 * k : 77;
            total++;
            if (int'(o_left_duty) != exp_d || int'(o_right_duty) != exp_d) begin
                bad++;
                $display("FAIL ramp_step[%0d]: l=%0d r=%0d required %0d", k,
                         o_left_duty, o_right_duty, exp_d);
            end
        end
        n = 0;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (o_fault) break;
        end
        total++;
        if (o_fault !== 1'b1 || o_left_duty !== 8'd0 || o_right_duty !== 8'd0) begin
            bad++;
            $display("FAIL ramp_fault_drop: fault=%0b l=%0d r=%0d required 1/0/0",
                     o_fault, o_left_duty, o_right_duty);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
`ifdef MOTOR_RAMP_EN
        test_ramp();
`else
        test_zero_steer();
        test_steering();
        test_back_to_back();
        test_watchdog();
        test_async_reset();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
